// File: rtl/perspective_params_ctrl_if.sv
// Corner/coefficient bundle between the corner detector, the perspective_params
// datapath, the pixel mapper and the perspective_params_ctrl controller.
// master: the environment side (detector, datapath, frame timing).
// slave : the controller side.
interface perspective_params_ctrl_if;
    logic               corners_valid;
    logic               corners_ready;
    logic        [6:0]  cx1, cx2, cx3, cx4;
    logic        [5:0]  cy1, cy2, cy3, cy4;
    logic        [6:0]  dx1, dx2, dx3, dx4;
    logic        [5:0]  dy1, dy2, dy3, dy4;
    logic signed [25:0] p1, p2, c1, c2;
    logic signed [27:0] p3, c3;
    logic signed [24:0] p4, p5, c4, c5;
    logic signed [26:0] p6, c6;
    logic signed [17:0] p7, p8, c7, c8;
    logic signed [19:0] p9, c9;
    logic               frame_start;
    logic               coeffs_valid;
    logic               coeff_update;
    logic               reject;
    logic               busy;

    modport master (
        output corners_valid, cx1, cx2, cx3, cx4, cy1, cy2, cy3, cy4,
        output p1, p2, p3, p4, p5, p6, p7, p8, p9, frame_start,
        input  corners_ready, dx1, dx2, dx3, dx4, dy1, dy2, dy3, dy4,
        input  c1, c2, c3, c4, c5, c6, c7, c8, c9,
        input  coeffs_valid, coeff_update, reject, busy
    );

    modport slave (
        input  corners_valid, cx1, cx2, cx3, cx4, cy1, cy2, cy3, cy4,
        input  p1, p2, p3, p4, p5, p6, p7, p8, p9, frame_start,
        output corners_ready, dx1, dx2, dx3, dx4, dy1, dy2, dy3, dy4,
        output c1, c2, c3, c4, c5, c6, c7, c8, c9,
        output coeffs_valid, coeff_update, reject, busy
    );
endinterface

// File: rtl/perspective_params_ctrl.sv
// perspective_params_ctrl: latches a corner set, drives the combinational
// perspective_params datapath, waits SETTLE_CYCLES for it to settle, snapshots
// the nine coefficients into a shadow bank and publishes them atomically to the
// active bank on the next frame_start.
// Optional build macro PERSPECTIVE_DEGEN_CHECK_EN: discard (reject) any snapshot
// whose p9 is zero, since that describes a degenerate quad.
module perspective_params_ctrl #(
    parameter int SETTLE_CYCLES = 4
) (
    input  logic                      clock,
    input  logic                      reset,
    perspective_params_ctrl_if.slave  ifc
);
    localparam logic [3:0] CNT_LOAD = 4'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SETTLE  = 2'd1,
        ST_CHECK   = 2'd2,
        ST_PENDING = 2'd3
    } state_t;

    state_t             r_state, w_state_nxt;
    logic        [3:0]  r_cnt, w_cnt_nxt;
    logic               w_accept, w_capture, w_publish;
    logic               r_ready, r_busy, r_coeffs_valid, r_coeff_update;
    logic        [6:0]  r_dx1, r_dx2, r_dx3, r_dx4;
    logic        [5:0]  r_dy1, r_dy2, r_dy3, r_dy4;
    logic signed [25:0] r_s1, r_s2, r_c1, r_c2;
    logic signed [27:0] r_s3, r_c3;
    logic signed [24:0] r_s4, r_s5, r_c4, r_c5;
    logic signed [26:0] r_s6, r_c6;
    logic signed [17:0] r_s7, r_s8, r_c7, r_c8;
    logic signed [19:0] r_s9, r_c9;
`ifdef PERSPECTIVE_DEGEN_CHECK_EN
    logic               w_reject;
    logic               r_reject;
`endif

    // State and settle counter registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next-state logic and the per-cycle strobes that steer the register banks.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_accept    = 1'b0;
        w_capture   = 1'b0;
        w_publish   = 1'b0;
`ifdef PERSPECTIVE_DEGEN_CHECK_EN
        w_reject    = 1'b0;
`endif
        case (r_state)
            ST_IDLE: begin
                if (ifc.corners_valid) begin
                    w_accept    = 1'b1;
                    w_cnt_nxt   = CNT_LOAD;
                    w_state_nxt = ST_SETTLE;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_SETTLE: begin
                if (r_cnt == 4'd0) begin
                    w_capture   = 1'b1;
                    w_state_nxt = ST_CHECK;
                end else begin
                    w_cnt_nxt   = r_cnt - 4'd1;
                end
            end
            ST_CHECK: begin
`ifdef PERSPECTIVE_DEGEN_CHECK_EN
                if (r_s9 == 20'sd0) begin
                    w_reject    = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_PENDING;
                end
`else
                w_state_nxt = ST_PENDING;
`endif
            end
            ST_PENDING: begin
                // frame_start is only meaningful here; elsewhere it is ignored.
                if (ifc.frame_start) begin
                    w_publish   = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_PENDING;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Registered status outputs, decoded from the upcoming state.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_ready        <= 1'b1;
            r_busy         <= 1'b0;
            r_coeffs_valid <= 1'b0;
            r_coeff_update <= 1'b0;
        end else begin
            r_ready        <= (w_state_nxt == ST_IDLE);
            r_busy         <= (w_state_nxt != ST_IDLE);
            r_coeffs_valid <= r_coeffs_valid | w_publish;
            r_coeff_update <= w_publish;
        end
    end

`ifdef PERSPECTIVE_DEGEN_CHECK_EN
    // One-cycle reject pulse when a degenerate snapshot is discarded.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_reject <= 1'b0;
        end else begin
            r_reject <= w_reject;
        end
    end
    assign ifc.reject = r_reject;
`else
    assign ifc.reject = 1'b0;
`endif

    // Corner registers feeding the datapath; held stable between accepts.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            {r_dx1, r_dx2, r_dx3, r_dx4} <= 28'd0;
            {r_dy1, r_dy2, r_dy3, r_dy4} <= 24'd0;
        end else if (w_accept) begin
            {r_dx1, r_dx2, r_dx3, r_dx4} <= {ifc.cx1, ifc.cx2, ifc.cx3, ifc.cx4};
            {r_dy1, r_dy2, r_dy3, r_dy4} <= {ifc.cy1, ifc.cy2, ifc.cy3, ifc.cy4};
        end
    end

    // Shadow bank: bit-exact snapshot of the settled datapath outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            {r_s1, r_s2, r_s3, r_s4, r_s5} <= 130'd0;
            {r_s6, r_s7, r_s8, r_s9}       <= 83'd0;
        end else if (w_capture) begin
            {r_s1, r_s2, r_s3, r_s4, r_s5} <= {ifc.p1, ifc.p2, ifc.p3, ifc.p4, ifc.p5};
            {r_s6, r_s7, r_s8, r_s9}       <= {ifc.p6, ifc.p7, ifc.p8, ifc.p9};
        end
    end

    // Active bank: all nine coefficients switch together on publish only.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            {r_c1, r_c2, r_c3, r_c4, r_c5} <= 130'd0;
            {r_c6, r_c7, r_c8, r_c9}       <= 83'd0;
        end else if (w_publish) begin
            {r_c1, r_c2, r_c3, r_c4, r_c5} <= {r_s1, r_s2, r_s3, r_s4, r_s5};
            {r_c6, r_c7, r_c8, r_c9}       <= {r_s6, r_s7, r_s8, r_s9};
        end
    end

    assign ifc.corners_ready = r_ready;
    assign ifc.busy          = r_busy;
    assign ifc.coeffs_valid  = r_coeffs_valid;
    assign ifc.coeff_update  = r_coeff_update;
    assign {ifc.dx1, ifc.dx2, ifc.dx3, ifc.dx4} = {r_dx1, r_dx2, r_dx3, r_dx4};
    assign {ifc.dy1, ifc.dy2, ifc.dy3, ifc.dy4} = {r_dy1, r_dy2, r_dy3, r_dy4};
    assign {ifc.c1, ifc.c2, ifc.c3, ifc.c4, ifc.c5} = {r_c1, r_c2, r_c3, r_c4, r_c5};
    assign {ifc.c6, ifc.c7, ifc.c8, ifc.c9}         = {r_c6, r_c7, r_c8, r_c9};
endmodule

// File: doc/perspective_params_ctrl.md
PERSPECTIVE_PARAMS_CTRL -- requirements
Module: perspective_params_ctrl

Interface
REQ-001 Parameter SETTLE_CYCLES, default 4: clock cycles allowed for the combinational perspective_params datapath to settle after its inputs change; legal range 1..15.
REQ-002 clock  input  1  system clock; all state changes on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 corners_valid  input  1  corner set x1..y4 presented by the corner detector.
REQ-005 cx1,cx2,cx3,cx4  input  7 each  corner x coordinates, unsigned.
REQ-006 cy1,cy2,cy3,cy4  input  6 each  corner y coordinates, unsigned.
REQ-007 corners_ready  output  1  controller accepts a corner set this cycle.
REQ-008 dx1..dx4 (7 each), dy1..dy4 (6 each)  output  registered corner values driving the perspective_params datapath.
REQ-009 p1,p2 (26), p3 (28), p4,p5 (25), p6 (27), p7,p8 (18), p9 (20)  input  signed datapath coefficients.
REQ-010 frame_start  input  1  one-cycle pulse at the start of each output frame.
REQ-011 c1..c9  output  same widths/signedness as p1..p9  active coefficients used by the pixel mapper.
REQ-012 coeffs_valid  output  1  level; at least one coefficient set has been published since reset.
REQ-013 coeff_update  output  1  one-cycle pulse in the cycle c1..c9 change.
REQ-014 reject  output  1  one-cycle pulse when a computed set is discarded.
REQ-015 busy  output  1  high in every state except IDLE.

Function
REQ-016 States: IDLE, SETTLE, CHECK, PENDING.
REQ-017 IDLE: corners_ready=1; on corners_valid=1, register cx/cy into dx/dy, load settle counter with SETTLE_CYCLES-1, go to SETTLE.
REQ-018 corners_ready SHALL be 0 in SETTLE, CHECK and PENDING; corners_valid in those states is ignored and not stored.
REQ-019 SETTLE: decrement counter each cycle; in the cycle the counter is 0, capture p1..p9 into shadow registers and go to CHECK (capture at edge T+SETTLE_CYCLES, T = accept edge).
REQ-020 CHECK (one cycle): go to PENDING, or go to IDLE with reject pulsed per REQ-029.
REQ-021 PENDING: on frame_start=1, copy shadow to c1..c9, pulse coeff_update, set coeffs_valid=1, go to IDLE.
REQ-022 frame_start outside PENDING SHALL be ignored; a set completing mid-frame waits for the next frame_start.
REQ-023 c1..c9 SHALL change only together, only in the coeff_update cycle; never partially updated.
REQ-024 dx/dy SHALL hold stable from accept until the next accept.
REQ-025 Shadow/active registers are bit-exact copies of p inputs; no truncation, rounding or sign change.

Reset
REQ-026 reset SHALL asynchronously force state IDLE, counter 0, dx/dy 0, shadow 0, c1..c9 0, coeffs_valid 0, coeff_update 0, reject 0, busy 0.
REQ-027 reset in any state SHALL discard any in-flight set; no coeff_update or reject follows release.
REQ-028 After release, corners_ready=1 in the first cycle.

Configuration
REQ-029 Macro PERSPECTIVE_DEGEN_CHECK_EN: when defined, CHECK rejects the set if shadow p9==0 (degenerate quad): pulse reject, keep c1..c9 and coeffs_valid unchanged, return to IDLE; when undefined, CHECK always proceeds to PENDING and reject is tied 0.

Verification
REQ-030 Reset, SETTLE_CYCLES=4, corners (50,30),(45,51),(29,47),(45,16) valid one cycle, frame_start at cycle 20 -> corners_ready low the cycle after accept, shadow captured 4 edges after accept, c1..c9 unchanged until frame_start, coeff_update one cycle later with c equal to datapath outputs for those corners, coeffs_valid=1.
REQ-031 Same corners, frame_start pulsed during SETTLE and again 30 cycles later -> first pulse ignored, update only on second.
REQ-032 Bench stubs p9=0 (macro defined) -> reject pulse the cycle after CHECK entry, c1..c9/coeffs_valid unchanged, corners_ready=1 next cycle; macro undefined -> set published normally on next frame_start.
REQ-033 reset asserted in PENDING with a valid shadow -> all outputs 0 immediately, no coeff_update after release even with frame_start.
REQ-034 corners_valid held high with new corners (10,5),(100,5),(100,60),(10,60) throughout a busy period -> not accepted until IDLE, then accepted in the first IDLE cycle; dx/dy match those values.
